// File: rtl/key_debounce.sv
// Synchroniser + per-bit debouncer for board keys/switches, with one-cycle press/release pulses.
// Define KEY_DEBOUNCE_LONGPRESS_EN to build the per-key long-press detector driving key_long.
module key_debounce #(
    parameter int N_KEYS          = 2,
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int KEYS_ACTIVE_LOW = 1,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [N_KEYS-1:0] keys_raw,
    input  logic [N_SW-1:0]   switches_raw,
    output logic [N_KEYS-1:0] keys_clean,
    output logic [N_SW-1:0]   switches_clean,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    localparam int NB = N_KEYS + N_SW;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_params
            $error("key_debounce: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
        end
    endgenerate

    logic [N_KEYS-1:0] keys_norm;
    logic [NB-1:0]     raw_norm;

    // Keys are normalised to 1 = pressed before they enter the synchroniser.
    assign keys_norm = (KEYS_ACTIVE_LOW != 0) ? ~keys_raw : keys_raw;
    assign raw_norm  = {switches_raw, keys_norm};

    logic [NB-1:0]     s1_q;
    logic [NB-1:0]     s2_q;
    logic [NB-1:0]     st_q;
    logic [NB-1:0]     st_d;
    logic [CW-1:0]     cnt_q [NB];
    logic [CW-1:0]     cnt_d [NB];
    logic [N_KEYS-1:0] kprev_q;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] release_q;

    // Any sample equal to the stable level restarts the count from zero.
    always_comb begin
        st_d = st_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != st_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    st_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            st_q      <= '0;
            cnt_q     <= '{default: '0};
            kprev_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            s1_q      <= raw_norm;
            s2_q      <= s1_q;
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            kprev_q   <= st_q[N_KEYS-1:0];
            press_q   <= st_q[N_KEYS-1:0] & ~kprev_q;
            release_q <= ~st_q[N_KEYS-1:0] & kprev_q;
        end
    end

    assign keys_clean     = st_q[N_KEYS-1:0];
    assign switches_clean = st_q[NB-1:N_KEYS];
    assign key_press      = press_q;
    assign key_release    = release_q;

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

    logic [HW-1:0]     hold_q [N_KEYS];
    logic [HW-1:0]     hold_d [N_KEYS];
    logic [N_KEYS-1:0] fired_q;
    logic [N_KEYS-1:0] fired_d;
    logic [N_KEYS-1:0] long_q;
    logic [N_KEYS-1:0] long_d;

    // Hold counter saturates at HOLD_MAX; fired limits the pulse to one per press.
    always_comb begin
        fired_d = '0;
        long_d  = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            hold_d[i] = '0;
            if (st_q[i]) begin
                hold_d[i]  = (hold_q[i] == HOLD_MAX) ? hold_q[i] : hold_q[i] + 1'b1;
                long_d[i]  = (hold_d[i] == HOLD_MAX) && !fired_q[i];
                fired_d[i] = fired_q[i] | long_d[i];
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            hold_q  <= '{default: '0};
            fired_q <= '0;
            long_q  <= '0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign key_long = long_q;
`else
    assign key_long = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: vector table for level timing, event scoreboard for press/release/long pulses.
module tb_key_debounce;

    localparam int D = 8;
    localparam int L = 20;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic [1:0] keys_raw;
    logic [3:0] switches_raw;
    logic [1:0] keys_clean;
    logic [3:0] switches_clean;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [1:0] key_long;

    key_debounce #(
        .N_KEYS(2),
        .N_SW(4),
        .DEBOUNCE_CYCLES(D),
        .KEYS_ACTIVE_LOW(1),
        .LONG_CYCLES(L)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .keys_raw(keys_raw),
        .switches_raw(switches_raw),
        .keys_clean(keys_clean),
        .switches_clean(switches_clean),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lng;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [1:0] keys_raw;
        logic [3:0] sw_raw;
        logic [1:0] exp_kc;
        logic [3:0] exp_sc;
        logic [1:0] exp_press;
        logic [1:0] exp_rel;
    } vec_t;
    vec_t vecs[7];

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        do @(negedge clk_clk); while (cyc < c);
    endtask

    task automatic chk_clean(input string nm, input int c, input logic [1:0] ek, input logic [3:0] es);
        wait_to(c);
        checks++;
        if (keys_clean !== ek || switches_clean !== es) begin
            failures++;
            $display("FAIL %s cyc=%0d got keys_clean=%b switches_clean=%b expected %b %b",
                     nm, cyc, keys_clean, switches_clean, ek, es);
        end
    endtask

    task automatic push_ev(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] lg);
        ev_t e;
        e.cyc = c;
        e.press = p;
        e.rel = r;
        e.lng = lg;
        sb.push_back(e);
    endtask

    // Pulse monitor: every nonzero pulse cycle must match the head of the scoreboard.
    always @(negedge clk_clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL event_missing expected at cyc=%0d press=%b release=%b long=%b",
                     sb[0].cyc, sb[0].press, sb[0].rel, sb[0].lng);
            void'(sb.pop_front());
        end
        if ((key_press | key_release | key_long) != 2'b00 || (sb.size() > 0 && sb[0].cyc == cyc)) begin
            checks++;
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
                failures++;
                $display("FAIL event_unexpected cyc=%0d got press=%b release=%b long=%b expected none",
                         cyc, key_press, key_release, key_long);
            end else begin
                if ({key_press, key_release, key_long} !== {sb[0].press, sb[0].rel, sb[0].lng}) begin
                    failures++;
                    $display("FAIL event_value cyc=%0d got press=%b release=%b long=%b expected %b %b %b",
                             cyc, key_press, key_release, key_long, sb[0].press, sb[0].rel, sb[0].lng);
                end
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int cf;
        int cr;
        logic [1:0] prev_k;
        logic [3:0] prev_s;
        logic [1:0] exp_lng_press;
        bit bad;

        // keys_raw is active-low: 0 = pressed
        vecs[0] = '{2'b10, 4'b0000, 2'b01, 4'b0000, 2'b01, 2'b00};
        vecs[1] = '{2'b11, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b01};
        vecs[2] = '{2'b11, 4'b0101, 2'b00, 4'b0101, 2'b00, 2'b00};
        vecs[3] = '{2'b00, 4'b1010, 2'b11, 4'b1010, 2'b11, 2'b00};
        vecs[4] = '{2'b11, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b11};
        vecs[5] = '{2'b01, 4'b1111, 2'b10, 4'b1111, 2'b10, 2'b00};
        vecs[6] = '{2'b11, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b10};

        reset_reset  = 1'b1;
        keys_raw     = 2'b11;
        switches_raw = 4'b0000;
        repeat (3) step();
        checks++;
        if ({keys_clean, switches_clean, key_press, key_release, key_long} !== 12'h000) begin
            failures++;
            $display("FAIL reset_state got %b expected all zero",
                     {keys_clean, switches_clean, key_press, key_release, key_long});
        end
        reset_reset = 1'b0;
        repeat (12) step();

        prev_k = 2'b00;
        prev_s = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            step();
            c0 = cyc;
            keys_raw     = vecs[i].keys_raw;
            switches_raw = vecs[i].sw_raw;
            if (vecs[i].exp_press != 2'b00 || vecs[i].exp_rel != 2'b00)
                push_ev(c0 + D + 3, vecs[i].exp_press, vecs[i].exp_rel, 2'b00);
            chk_clean($sformatf("vec%0d_before", i), c0 + D + 1, prev_k, prev_s);
            chk_clean($sformatf("vec%0d_after", i), c0 + D + 2, vecs[i].exp_kc, vecs[i].exp_sc);
            prev_k = vecs[i].exp_kc;
            prev_s = vecs[i].exp_sc;
            wait_to(c0 + 16);
        end

        // Bounce on key 1: low 3, high 2, then low and held.
        step();
        keys_raw[1] = 1'b0;
        repeat (3) step();
        keys_raw[1] = 1'b1;
        repeat (2) step();
        keys_raw[1] = 1'b0;
        cf = cyc;
        push_ev(cf + D + 3, 2'b10, 2'b00, 2'b00);
        chk_clean("bounce_before", cf + D + 1, 2'b00, 4'b0000);
        chk_clean("bounce_after", cf + D + 2, 2'b10, 4'b0000);
        wait_to(cf + 14);
        step();
        keys_raw[1] = 1'b1;
        c0 = cyc;
        push_ev(c0 + D + 3, 2'b00, 2'b10, 2'b00);
        chk_clean("bounce_release", c0 + D + 2, 2'b00, 4'b0000);
        wait_to(c0 + 14);

        // Glitch of D-1 cycles on switch 2 is rejected.
        step();
        switches_raw[2] = 1'b1;
        repeat (D - 1) step();
        switches_raw[2] = 1'b0;
        bad = 1'b0;
        repeat (14) begin
            @(negedge clk_clk);
            if (switches_clean !== 4'b0000) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL glitch_reject got switches_clean nonzero expected 0000");
        end

        // Exactly D cycles on switch 3 is accepted, and falls D+2 edges after release.
        step();
        switches_raw[3] = 1'b1;
        c0 = cyc;
        repeat (D) step();
        switches_raw[3] = 1'b0;
        chk_clean("accept_before", c0 + D + 1, 2'b00, 4'b0000);
        chk_clean("accept_rise", c0 + D + 2, 2'b00, 4'b1000);
        chk_clean("accept_hold", c0 + 2 * D + 1, 2'b00, 4'b1000);
        chk_clean("accept_fall", c0 + 2 * D + 2, 2'b00, 4'b0000);
        wait_to(c0 + 2 * D + 6);

        // Reset in the middle of a key count; switch 0 already stable beforehand.
        step();
        switches_raw[0] = 1'b1;
        c0 = cyc;
        chk_clean("pre_reset_sw", c0 + D + 2, 2'b00, 4'b0001);
        wait_to(c0 + 12);
        step();
        keys_raw[0] = 1'b0;
        repeat (5) step();
        reset_reset = 1'b1;
        cr = cyc;
        wait_to(cr + 1);
        checks++;
        if ({keys_clean, switches_clean, key_press, key_release, key_long} !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid_count got %b expected all zero",
                     {keys_clean, switches_clean, key_press, key_release, key_long});
        end
        reset_reset = 1'b0;
        push_ev(cr + 2 + D + 2, 2'b01, 2'b00, 2'b00);
        chk_clean("post_reset_before", cr + 2 + D, 2'b00, 4'b0000);
        chk_clean("post_reset_after", cr + 2 + D + 1, 2'b01, 4'b0001);
        step();
        keys_raw     = 2'b11;
        switches_raw = 4'b0000;
        c0 = cyc;
        push_ev(c0 + D + 3, 2'b00, 2'b01, 2'b00);
        chk_clean("post_reset_release", c0 + D + 2, 2'b00, 4'b0000);
        wait_to(c0 + 14);

        // Long hold on key 0: 40 cycles past debounce.
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
        exp_lng_press = 2'b01;
`else
        exp_lng_press = 2'b00;
`endif
        step();
        keys_raw[0] = 1'b0;
        c0 = cyc;
        push_ev(c0 + D + 3, 2'b01, 2'b00, 2'b00);
        if (exp_lng_press != 2'b00) push_ev(c0 + D + 2 + L, 2'b00, 2'b00, exp_lng_press);
        chk_clean("long_rise", c0 + D + 2, 2'b01, 4'b0000);
        wait_to(c0 + D + 2 + 40);
        step();
        keys_raw[0] = 1'b1;
        c0 = cyc;
        push_ev(c0 + D + 3, 2'b00, 2'b01, 2'b00);
        chk_clean("long_release", c0 + D + 2, 2'b00, 4'b0000);
        wait_to(c0 + 40);

        repeat (5) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending events expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
